// File: rtl/mem_pkg.sv
// Shared types, default parameters and the CPU address decoder.
package mem_pkg;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_VRAM,
    REG_NONE
  } region_t;

  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned ADDR_W_DEF     = 16;
  localparam int unsigned RAM_AW_DEF     = 13;
  localparam int unsigned VRAM_AW_DEF    = 10;
  localparam int unsigned VRAM_BASE_DEF  = 32'hE000;
  localparam int unsigned RD_LAT_DEF     = 1;
  localparam int unsigned STARVE_MAX_DEF = 4;

  // RAM sits at 0; VRAM is a 2^vram_aw window at vram_base; the rest is unmapped.
  function automatic region_t decode_region(
    input logic [31:0] addr,
    input int unsigned ram_aw    = RAM_AW_DEF,
    input int unsigned vram_aw   = VRAM_AW_DEF,
    input int unsigned vram_base = VRAM_BASE_DEF
  );
    logic [32:0] a;
    logic [32:0] ram_top;
    logic [32:0] vram_lo;
    logic [32:0] vram_hi;
    a       = {1'b0, addr};
    ram_top = 33'd1 << ram_aw;
    vram_lo = 33'(vram_base);
    vram_hi = vram_lo + (33'd1 << vram_aw);
    if (a < ram_top) return REG_RAM;
    if (a >= vram_lo && a < vram_hi) return REG_VRAM;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/mem_subsys_sdp_bram.sv
// Simple-dual-port block RAM: one write port, one read port, optional output register.
module sdp_bram #(
  parameter int unsigned AW     = 10,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_q;

  // Read-before-write: a same-edge read of the written word returns the old value.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rd_q <= mem[raddr];
  end

  if (RD_LAT == 2) begin : g_oce
    logic [DW-1:0] oce_q;
    // Output register stage.
    always_ff @(posedge clk) begin
      oce_q <= rd_q;
    end
    assign rdata = oce_q;
  end else begin : g_no_oce
    assign rdata = rd_q;
  end

endmodule

// File: rtl/mem_subsys.sv
// CPU-port address decode onto main RAM and text VRAM, with an LCD scan-out
// read port sharing the VRAM read port.
module mem_subsys
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned RAM_AW     = RAM_AW_DEF,
  parameter int unsigned VRAM_AW    = VRAM_AW_DEF,
  parameter int unsigned VRAM_BASE  = VRAM_BASE_DEF,
  parameter int unsigned RD_LAT     = RD_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic               MEMORY_CLK,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic               cpu_ready,
  output logic               cpu_rvalid,
  output logic [DATA_W-1:0]  cpu_rdata,
  input  logic               lcd_req,
  input  logic [VRAM_AW-1:0] lcd_addr,
  output logic               lcd_ready,
  output logic               lcd_rvalid,
  output logic [DATA_W-1:0]  lcd_rdata
);

  localparam int unsigned SW    = $clog2(STARVE_MAX + 1);
  localparam int unsigned RW    = $bits(region_t);
  localparam int unsigned SRC_W = RW * RD_LAT;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  region_t            cpu_region;
  logic               cpu_is_vram_rd;
  logic               starve_full;
  logic               cpu_acc;
  logic               lcd_acc;
  logic               cpu_vram_grant;
  logic               ram_we;
  logic               ram_re;
  logic               vram_we;
  logic               vram_re;
  logic [VRAM_AW-1:0] vram_raddr;
  logic [DATA_W-1:0]  ram_rdata;
  logic [DATA_W-1:0]  vram_rdata;
  logic [DATA_W-1:0]  cpu_ret_data;

  logic [SW-1:0]      starve_q, starve_d;
  logic [RD_LAT-1:0]  cpu_vld_q, cpu_vld_d;
  logic [RD_LAT-1:0]  lcd_vld_q, lcd_vld_d;
  logic [SRC_W-1:0]   cpu_src_q, cpu_src_d;
  logic [DATA_W-1:0]  cpu_hold_q, cpu_hold_d;
  logic [DATA_W-1:0]  lcd_hold_q, lcd_hold_d;

  // Decode, VRAM read-port arbitration and starvation counter.
  always_comb begin
    cpu_region     = decode_region(32'(cpu_addr), RAM_AW, VRAM_AW, VRAM_BASE);
    starve_full    = (starve_q == STARVE_LIM);
    cpu_is_vram_rd = !cpu_we && (cpu_region == REG_VRAM);
    cpu_ready      = !reset && !(cpu_is_vram_rd && lcd_req && !starve_full);
    lcd_ready      = !reset && !(cpu_req && cpu_is_vram_rd && starve_full);
    cpu_acc        = cpu_req && cpu_ready;
    lcd_acc        = lcd_req && lcd_ready;
    cpu_vram_grant = cpu_acc && cpu_is_vram_rd;
    ram_we         = cpu_acc && cpu_we && (cpu_region == REG_RAM);
    vram_we        = cpu_acc && cpu_we && (cpu_region == REG_VRAM);
    ram_re         = cpu_acc && !cpu_we && (cpu_region == REG_RAM);
    vram_re        = cpu_vram_grant || lcd_acc;
    vram_raddr     = cpu_vram_grant ? cpu_addr[VRAM_AW-1:0] : lcd_addr;
    starve_d       = '0;
    if (cpu_req && cpu_is_vram_rd && !cpu_ready)
      starve_d = starve_full ? starve_q : starve_q + SW'(1);
  end

  // In-flight pipelines (new entry shifts in at the bottom) and retirement muxing.
  always_comb begin
    cpu_vld_d  = RD_LAT'({cpu_vld_q, cpu_acc && !cpu_we});
    lcd_vld_d  = RD_LAT'({lcd_vld_q, lcd_acc});
    cpu_src_d  = SRC_W'({cpu_src_q, cpu_region});
    cpu_rvalid = cpu_vld_q[RD_LAT-1];
    lcd_rvalid = lcd_vld_q[RD_LAT-1];
    case (region_t'(cpu_src_q[SRC_W-1 -: RW]))
      REG_RAM:  cpu_ret_data = ram_rdata;
      REG_VRAM: cpu_ret_data = vram_rdata;
      default:  cpu_ret_data = '0;
    endcase
    cpu_hold_d = cpu_rvalid ? cpu_ret_data : cpu_hold_q;
    lcd_hold_d = lcd_rvalid ? vram_rdata : lcd_hold_q;
    cpu_rdata  = cpu_hold_d;
    lcd_rdata  = lcd_hold_d;
  end

  // State registers; reset flushes reads still in flight.
  always_ff @(posedge MEMORY_CLK) begin
    if (reset) begin
      starve_q   <= '0;
      cpu_vld_q  <= '0;
      lcd_vld_q  <= '0;
      cpu_src_q  <= '0;
      cpu_hold_q <= '0;
      lcd_hold_q <= '0;
    end else begin
      starve_q   <= starve_d;
      cpu_vld_q  <= cpu_vld_d;
      lcd_vld_q  <= lcd_vld_d;
      cpu_src_q  <= cpu_src_d;
      cpu_hold_q <= cpu_hold_d;
      lcd_hold_q <= lcd_hold_d;
    end
  end

  sdp_bram #(.AW(RAM_AW), .DW(DATA_W), .RD_LAT(RD_LAT)) u_ram (
    .clk   (MEMORY_CLK),
    .we    (ram_we),
    .waddr (cpu_addr[RAM_AW-1:0]),
    .wdata (cpu_wdata),
    .re    (ram_re),
    .raddr (cpu_addr[RAM_AW-1:0]),
    .rdata (ram_rdata)
  );

  sdp_bram #(.AW(VRAM_AW), .DW(DATA_W), .RD_LAT(RD_LAT)) u_vram (
    .clk   (MEMORY_CLK),
    .we    (vram_we),
    .waddr (cpu_addr[VRAM_AW-1:0]),
    .wdata (cpu_wdata),
    .re    (vram_re),
    .raddr (vram_raddr),
    .rdata (vram_rdata)
  );

endmodule

// File: tb/tb_mem_subsys.sv
`timescale 1ns/1ps
module tb_mem_subsys;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cpu_req, cpu_we, lcd_req;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [9:0]  lcd_addr;
  logic        c_rdy [2], c_rv [2], l_rdy [2], l_rv [2];
  logic [7:0]  c_rd [2], l_rd [2];

  mem_subsys #(.RD_LAT(1)) dut1 (
    .MEMORY_CLK(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(c_rdy[0]),
    .cpu_rvalid(c_rv[0]), .cpu_rdata(c_rd[0]), .lcd_req(lcd_req),
    .lcd_addr(lcd_addr), .lcd_ready(l_rdy[0]), .lcd_rvalid(l_rv[0]), .lcd_rdata(l_rd[0])
  );

  mem_subsys #(.RD_LAT(2)) dut2 (
    .MEMORY_CLK(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(c_rdy[1]),
    .cpu_rvalid(c_rv[1]), .cpu_rdata(c_rd[1]), .lcd_req(lcd_req),
    .lcd_addr(lcd_addr), .lcd_ready(l_rdy[1]), .lcd_rvalid(l_rv[1]), .lcd_rdata(l_rd[1])
  );

  // Reference model state
  localparam int LAT [2] = '{1, 2};
  logic [7:0]  ram_m [8192];
  logic [7:0]  vram_m [1024];
  int          starve_m;
  int          cyc;
  bit          ev_c [2][8];
  bit          ev_l [2][8];
  logic [7:0]  ed_c [2][8];
  logic [7:0]  ed_l [2][8];
  logic [7:0]  hold_c [2];
  logic [7:0]  hold_l [2];
  logic        exp_crdy, exp_lrdy;
  logic        exp_cv [2];
  logic        exp_lv [2];
  int          vectors;
  int          miscompares;

  // 0 = RAM, 1 = VRAM, 2 = unmapped
  function automatic int reg_of(input logic [15:0] a);
    if (a < 16'h2000) return 0;
    if (a >= 16'hE000 && a < 16'hE400) return 1;
    return 2;
  endfunction

  function automatic logic [39:0] obs_vec();
    return {cpu_req & c_rdy[0], lcd_req & l_rdy[0], c_rv[0], c_rd[0], l_rv[0], l_rd[0],
            cpu_req & c_rdy[1], lcd_req & l_rdy[1], c_rv[1], c_rd[1], l_rv[1], l_rd[1]};
  endfunction

  function automatic logic [39:0] exp_vec();
    return {cpu_req & exp_crdy, lcd_req & exp_lrdy, exp_cv[0], hold_c[0], exp_lv[0], hold_l[0],
            cpu_req & exp_crdy, lcd_req & exp_lrdy, exp_cv[1], hold_c[1], exp_lv[1], hold_l[1]};
  endfunction

  task automatic drive(input logic req, input logic we, input logic [15:0] a,
                       input logic [7:0] wd, input logic lreq, input logic [9:0] la);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    lcd_req = lreq; lcd_addr = la;
  endtask

  // Compute expectations for the current cycle from the model.
  task automatic sample();
    int s;
    @(negedge clk);
    s = cyc % 8;
    for (int d = 0; d < 2; d++) begin
      exp_cv[d] = ev_c[d][s];
      if (ev_c[d][s]) hold_c[d] = ed_c[d][s];
      exp_lv[d] = ev_l[d][s];
      if (ev_l[d][s]) hold_l[d] = ed_l[d][s];
    end
    exp_crdy = !reset && !(!cpu_we && reg_of(cpu_addr) == 1 && lcd_req && starve_m != 4);
    exp_lrdy = !reset && !(cpu_req && !cpu_we && reg_of(cpu_addr) == 1 && starve_m == 4);
  endtask

  // Apply the clock edge to the model, then move inputs off the edge.
  task automatic advance();
    int r;
    logic [7:0] rd;
    @(posedge clk);
    r = reg_of(cpu_addr);
    if (reset) begin
      starve_m = 0;
      for (int d = 0; d < 2; d++) begin
        hold_c[d] = '0;
        hold_l[d] = '0;
        for (int k = 1; k <= 2; k++) begin
          ev_c[d][(cyc + k) % 8] = 0;
          ev_l[d][(cyc + k) % 8] = 0;
        end
      end
    end else begin
      if (cpu_req && exp_crdy && !cpu_we) begin
        rd = (r == 0) ? ram_m[cpu_addr[12:0]] : (r == 1) ? vram_m[cpu_addr[9:0]] : 8'h00;
        for (int d = 0; d < 2; d++) begin
          ev_c[d][(cyc + LAT[d]) % 8] = 1;
          ed_c[d][(cyc + LAT[d]) % 8] = rd;
        end
      end
      if (lcd_req && exp_lrdy) begin
        for (int d = 0; d < 2; d++) begin
          ev_l[d][(cyc + LAT[d]) % 8] = 1;
          ed_l[d][(cyc + LAT[d]) % 8] = vram_m[lcd_addr];
        end
      end
      if (cpu_req && exp_crdy && cpu_we) begin
        if (r == 0) ram_m[cpu_addr[12:0]] = cpu_wdata;
        else if (r == 1) vram_m[cpu_addr[9:0]] = cpu_wdata;
      end
      if (cpu_req && !cpu_we && r == 1 && !exp_crdy) starve_m = (starve_m < 4) ? starve_m + 1 : 4;
      else starve_m = 0;
    end
    for (int d = 0; d < 2; d++) begin
      ev_c[d][cyc % 8] = 0;
      ev_l[d][cyc % 8] = 0;
    end
    cyc++;
    #1;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1:    return 16'($urandom_range(0, 16'h1FFF));
      2, 3:    return 16'($urandom_range(16'hE000, 16'hE3FF));
      4:       return 16'($urandom_range(16'h2000, 16'hDFFF));
      default: return 16'($urandom_range(16'hE400, 16'hFFFF));
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 0, 16'hE000, 8'h00, 1, 10'd0);
    advance();
    advance();
    for (int t = 0; t < 3; t++) begin
      sample();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
      if ({c_rdy[0], c_rdy[1], l_rdy[0], l_rdy[1], c_rv[0], c_rv[1], l_rv[0], l_rv[1],
           c_rd[0], c_rd[1], l_rd[0], l_rd[1]} !== 40'h0) begin
        miscompares++;
        $display("FAIL reset_zero cyc=%0d rdy=%b%b%b%b rv=%b%b%b%b exp all 0", cyc,
                 c_rdy[0], c_rdy[1], l_rdy[0], l_rdy[1], c_rv[0], c_rv[1], l_rv[0], l_rv[1]);
      end
      vectors++;
      advance();
    end
    reset = 1'b0;
    drive(0, 0, 16'h0, 8'h0, 0, 10'd0);
  endtask

  task automatic test_fill();
    for (int a = 0; a < 8192 + 1024; a++) begin
      drive(1, 1, (a < 8192) ? 16'(a) : 16'(16'hE000 + a - 8192), 8'($urandom), 0, 10'd0);
      sample();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL fill cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
      advance();
    end
    drive(0, 0, 16'h0, 8'h0, 0, 10'd0);
  endtask

  task automatic test_write_read();
    for (int t = 0; t < 5; t++) begin
      if (t == 0) drive(1, 1, 16'h0010, 8'hA5, 0, 10'd0);
      else if (t == 1) drive(1, 0, 16'h0010, 8'h00, 0, 10'd0);
      else drive(0, 0, 16'h0, 8'h0, 0, 10'd0);
      sample();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL write_read cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
      for (int d = 0; d < 2; d++) begin
        if (t == 1 + LAT[d]) begin
          if (c_rv[d] !== 1'b1 || c_rd[d] !== 8'hA5) begin
            miscompares++;
            $display("FAIL write_read_lat%0d rvalid=%b rdata=%h exp 1/a5", LAT[d], c_rv[d], c_rd[d]);
          end
          vectors++;
        end
      end
      advance();
    end
  endtask

  task automatic test_vram_hazard();
    for (int t = 0; t < 6; t++) begin
      if (t == 0) drive(1, 1, 16'hE005, 8'h41, 0, 10'd0);
      else if (t == 1) drive(0, 0, 16'h0, 8'h0, 1, 10'd5);
      else if (t == 2) drive(1, 1, 16'hE005, 8'h42, 1, 10'd5);
      else drive(0, 0, 16'h0, 8'h0, 0, 10'd0);
      sample();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL vram_hazard cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
      for (int d = 0; d < 2; d++) begin
        if (t == 1 + LAT[d] || t == 2 + LAT[d]) begin
          if (l_rv[d] !== 1'b1 || l_rd[d] !== 8'h41) begin
            miscompares++;
            $display("FAIL vram_hazard_lat%0d t=%0d rvalid=%b rdata=%h exp 1/41", LAT[d], t, l_rv[d], l_rd[d]);
          end
          vectors++;
        end
      end
      advance();
    end
  endtask

  task automatic test_starve();
    int  denied;
    bit  granted;
    denied  = 0;
    granted = 0;
    drive(1, 0, 16'hE000, 8'h0, 1, 10'($urandom));
    for (int t = 0; t < 20 && !granted; t++) begin
      sample();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL starve cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
      if (c_rdy[0] === 1'b1) begin
        granted = 1;
        if (denied != 4 || l_rdy[0] !== 1'b0 || l_rdy[1] !== 1'b0 || c_rdy[1] !== 1'b1) begin
          miscompares++;
          $display("FAIL starve_grant denied=%0d lcd_ready=%b%b exp denied=4 lcd_ready=00",
                   denied, l_rdy[0], l_rdy[1]);
        end
        vectors++;
      end else begin
        denied++;
      end
      advance();
      lcd_addr = 10'($urandom);
    end
    if (!granted) begin
      miscompares++;
      $display("FAIL starve_timeout denied=%0d exp grant after 4", denied);
    end
    vectors++;
    // Counter must be back at zero: a held request is denied again right away.
    sample();
    if (obs_vec() !== exp_vec() || c_rdy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL starve_clear cpu_ready=%b exp 0 got=%h exp=%h", c_rdy[0], obs_vec(), exp_vec());
    end
    vectors++;
    advance();
    drive(0, 0, 16'h0, 8'h0, 0, 10'd0);
    for (int t = 0; t < 3; t++) begin
      sample();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL starve_drain cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
      advance();
    end
  endtask

  task automatic test_unmapped();
    logic [15:0] wa [4];
    wa = '{16'h8000, 16'h2000, 16'hDFFF, 16'hE400};
    for (int t = 0; t < 4; t++) begin
      if (t == 0) drive(1, 0, 16'h8000, 8'h0, 0, 10'd0);
      else drive(0, 0, 16'h0, 8'h0, 0, 10'd0);
      sample();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL unmapped_rd cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
      for (int d = 0; d < 2; d++) begin
        if (t == LAT[d]) begin
          if (c_rv[d] !== 1'b1 || c_rd[d] !== 8'h00) begin
            miscompares++;
            $display("FAIL unmapped_rd_lat%0d rvalid=%b rdata=%h exp 1/00", LAT[d], c_rv[d], c_rd[d]);
          end
          vectors++;
        end
      end
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, wa[i], 8'hFF, 0, 10'd0);
      sample();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL unmapped_wr cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
      advance();
    end
    for (int a = 0; a < 8192 + 1024 + 3; a++) begin
      if (a < 8192) drive(1, 0, 16'(a), 8'h0, 0, 10'd0);
      else if (a < 8192 + 1024) drive(1, 0, 16'(16'hE000 + a - 8192), 8'h0, 0, 10'd0);
      else drive(0, 0, 16'h0, 8'h0, 0, 10'd0);
      sample();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL readback cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
      advance();
    end
  endtask

  task automatic test_reset_inflight();
    for (int t = 0; t < 10; t++) begin
      reset = (t == 3);
      if (t < 4) drive(1, 0, 16'(100 + t), 8'h0, 0, 10'd0);
      else if (t == 7) drive(1, 0, 16'd100, 8'h0, 0, 10'd0);
      else drive(0, 0, 16'h0, 8'h0, 0, 10'd0);
      sample();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_inflight cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
      if (t >= 4 && t <= 7) begin
        if ({c_rv[0], c_rv[1], c_rd[0], c_rd[1]} !== 18'h0) begin
          miscompares++;
          $display("FAIL reset_flush t=%0d rvalid=%b%b rdata=%h/%h exp 0", t, c_rv[0], c_rv[1], c_rd[0], c_rd[1]);
        end
        vectors++;
      end
      advance();
    end
    reset = 1'b0;
  endtask

  task automatic test_simul();
    for (int t = 0; t < 4; t++) begin
      if (t == 0) drive(1, 0, 16'h0055, 8'h0, 1, 10'd7);
      else drive(0, 0, 16'h0, 8'h0, 0, 10'd0);
      sample();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL simul cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
      if (t == 0 && {c_rdy[0], l_rdy[0], c_rdy[1], l_rdy[1]} !== 4'hF) begin
        miscompares++;
        $display("FAIL simul_accept ready=%b%b%b%b exp 1111", c_rdy[0], l_rdy[0], c_rdy[1], l_rdy[1]);
      end
      if (t == 0) vectors++;
      for (int d = 0; d < 2; d++) begin
        if (t == LAT[d]) begin
          if (c_rv[d] !== 1'b1 || l_rv[d] !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_rvalid_lat%0d cpu=%b lcd=%b exp 1/1", LAT[d], c_rv[d], l_rv[d]);
          end
          vectors++;
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 3000; t++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4, rand_addr(), 8'($urandom),
            $urandom_range(0, 9) < 6, 10'($urandom));
      sample();
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      vectors++;
      advance();
    end
    reset = 1'b0;
    drive(0, 0, 16'h0, 8'h0, 0, 10'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d simulation did not complete", cyc);
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    starve_m    = 0;
    reset       = 1'b1;
    drive(0, 0, 16'h0, 8'h0, 0, 10'd0);
    #1;
    test_reset();
    test_fill();
    test_write_read();
    test_vram_hazard();
    test_starve();
    test_unmapped();
    test_reset_inflight();
    test_simul();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_subsys.md
Name: mem_subsys

Overview:
- Parametrised successor of the fixed RAM/VRAM pair: one CPU port decodes a flat address into main RAM and text VRAM, plus an LCD scan-out read port on VRAM.
- Both memories are simple-dual-port BSRAM (one write port, one read port); the VRAM read port is arbitrated between CPU and LCD.
- Configurable read latency (OCE output register on/off) and an anti-starvation guard for the CPU.
- Sits between the CPU core, the LCD text renderer and the BSRAM primitives.

Parameters:
- DATA_W, 8, data width of both memories.
- ADDR_W, 16, CPU address width.
- RAM_AW, 13, main RAM address width (8192 words, mapped at 0).
- VRAM_AW, 10, VRAM address width (1024 words).
- VRAM_BASE, 16'hE000, CPU base address of VRAM; must be aligned to 2^VRAM_AW and must not overlap RAM.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2 (2 = output register enabled).
- STARVE_MAX, 4, consecutive denied CPU VRAM reads before the CPU is forced a grant.

Ports:
- MEMORY_CLK  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  flat CPU address.
- cpu_wdata  in  DATA_W  write data.
- cpu_ready  out  1  combinational; request accepted at this edge.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata is valid.
- cpu_rdata  out  DATA_W  read data, held until the next cpu_rvalid.
- lcd_req  in  1  LCD read request.
- lcd_addr  in  VRAM_AW  VRAM word address.
- lcd_ready  out  1  combinational; LCD request accepted.
- lcd_rvalid  out  1  one-cycle pulse.
- lcd_rdata  out  DATA_W  held until the next lcd_rvalid.

Behaviour:
- Decode:
  - RAM when cpu_addr < 2^RAM_AW.
  - VRAM when VRAM_BASE <= cpu_addr < VRAM_BASE + 2^VRAM_AW.
  - Otherwise UNMAPPED.
- Writes:
  - Always accepted (cpu_ready = 1); the write port is CPU-private.
  - Memory is updated at the accepting edge. UNMAPPED writes are dropped silently.
- CPU RAM reads and UNMAPPED reads: always accepted. UNMAPPED reads return 0 with normal latency.
- VRAM read-port arbitration, evaluated each cycle:
  - LCD wins by default.
  - CPU wins if starve_cnt == STARVE_MAX; LCD then sees lcd_ready = 0.
  - With no conflict, each requester is granted.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each cycle a CPU VRAM read is pending but denied.
  - Clears on CPU grant or when cpu_req drops.
- Hazards:
  - A read the cycle after a write to the same address returns the new data.
  - An LCD read of an address the CPU writes in the same cycle returns the old data (read-before-write).
- Latency: every accepted read produces exactly one rvalid, RD_LAT cycles after the accepting edge, in issue order. Back-to-back reads sustain 1 per cycle per port.
- In-flight tracking: shift pipeline of depth RD_LAT carrying {valid, source region} per port; it selects the RAM, VRAM or zero data at retirement.
- Reset:
  - cpu_ready and lcd_ready are 0 while reset is high.
  - cpu_rvalid, lcd_rvalid, cpu_rdata, lcd_rdata and starve_cnt are 0.
  - The pipeline is flushed: reads accepted before reset never produce rvalid.
  - Memory contents are not cleared.
  - Reset asserted mid-burst takes effect at the next edge; the first post-reset access behaves as from power-up.

Decomposition:
- Package mem_pkg:
  - region_t enum {REG_RAM, REG_VRAM, REG_NONE}.
  - Default parameter constants.
  - Function decode_region(addr).
- Sub-module sdp_bram (params AW, DW, RD_LAT):
  - Inferred simple-dual-port block RAM with optional output register.
  - Instantiated twice.
  - Contains no arbitration.

Test Plan:
- Write 8'hA5 to 16'h0010, then read 16'h0010 -> cpu_rvalid after RD_LAT cycles with cpu_rdata = 8'hA5, for RD_LAT = 1 and RD_LAT = 2.
- Write 8'h41 to 16'hE005; LCD reads addr 5 one cycle later -> lcd_rdata = 8'h41. A same-cycle write of 8'h42 with an LCD read of addr 5 -> LCD gets 8'h41.
- CPU holds a VRAM read at 16'hE000 while the LCD requests every cycle -> cpu_ready = 0 for exactly STARVE_MAX (4) cycles, then 1. On that cycle lcd_ready = 0 and starve_cnt returns to 0.
- CPU reads 16'h8000 (unmapped) -> cpu_rvalid with cpu_rdata = 0. A write to 16'h8000 leaves RAM and VRAM unchanged (full readback check).
- Issue 3 back-to-back CPU RAM reads, then assert reset while 2 are in flight -> no further cpu_rvalid pulses and all outputs 0. RAM contents are intact when read after reset.
- Simultaneous CPU RAM read and LCD VRAM read -> both accepted; both rvalid pulses occur in the same cycle RD_LAT later.
